// File: rtl/id_ex_pipe_stage_pkg.sv
// Shared constants for the ID->EX stage: default widths, EX bundle field
// offsets and the all-zero bubble control values.
package id_ex_pipe_stage_pkg;

    localparam int DATA_W_DEF  = 32;
    localparam int REG_W_DEF   = 5;
    localparam int WB_W_DEF    = 4;
    localparam int MEM_W_DEF   = 5;
    localparam int ALUOP_W_DEF = 4;
    localparam int CNT_W_DEF   = 16;

    // EX bundle layout: {halfbyte[1:0], ALUOp, ALUSrc, RegDst[1:0]}
    localparam int REGDST_LSB = 0;
    localparam int ALUSRC_BIT = 2;
    localparam int ALUOP_LSB  = 3;

    function automatic int halfbyte_lsb(input int aluop_w);
        return ALUOP_LSB + aluop_w;
    endfunction

    localparam int HALFBYTE_LSB_DEF = ALUOP_LSB + ALUOP_W_DEF;

    localparam logic [WB_W_DEF-1:0]      WB_BUBBLE  = '0;
    localparam logic [MEM_W_DEF-1:0]     MEM_BUBBLE = '0;
    localparam logic [ALUOP_W_DEF+4:0]   EX_BUBBLE  = '0;

endpackage

// File: rtl/id_ex_pipe_stage_if.sv
// ID->EX stage bus: ID-side inputs, hazard controls and EX-side outputs.
// master = the surrounding datapath, slave = the pipeline stage itself.
interface id_ex_pipe_stage_if #(
    parameter int DATA_W  = 32,
    parameter int REG_W   = 5,
    parameter int WB_W    = 4,
    parameter int MEM_W   = 5,
    parameter int ALUOP_W = 4,
    parameter int CNT_W   = 16
);
    logic               Stall;
    logic               Flush;
    logic               ID_Valid;
    logic [WB_W-1:0]    ID_WB_Ctrl;
    logic [MEM_W-1:0]   ID_MEM_Ctrl;
    logic [ALUOP_W+4:0] ID_EX_Ctrl;
    logic [DATA_W-1:0]  ID_PCAddResult;
    logic [DATA_W-1:0]  ID_Read1;
    logic [DATA_W-1:0]  ID_Read2;
    logic [DATA_W-1:0]  ID_SignExtend;
    logic [DATA_W-1:0]  ID_SignExtend_10_6;
    logic [REG_W-1:0]   ID_Rs;
    logic [REG_W-1:0]   ID_Rt;
    logic [REG_W-1:0]   ID_Rd;

    logic               EX_Valid;
    logic [WB_W-1:0]    EX_WBCtrl;
    logic [MEM_W-1:0]   EX_MEMCtrl;
    logic [1:0]         EX_RegDst;
    logic               EX_ALUSrc;
    logic [ALUOP_W-1:0] EX_ALUOp;
    logic [1:0]         EX_halfbyte;
    logic [DATA_W-1:0]  EX_PCAddResult;
    logic [DATA_W-1:0]  EX_Read1;
    logic [DATA_W-1:0]  EX_Read2;
    logic [DATA_W-1:0]  EX_SignExtend;
    logic [DATA_W-1:0]  EX_SignExtend_10_6;
    logic [REG_W-1:0]   EX_Rs;
    logic [REG_W-1:0]   EX_Rt;
    logic [REG_W-1:0]   EX_Rd;
    logic [CNT_W-1:0]   StallCount;
    logic [CNT_W-1:0]   BubbleCount;

    modport master (
        output Stall, Flush, ID_Valid, ID_WB_Ctrl, ID_MEM_Ctrl, ID_EX_Ctrl,
               ID_PCAddResult, ID_Read1, ID_Read2, ID_SignExtend, ID_SignExtend_10_6,
               ID_Rs, ID_Rt, ID_Rd,
        input  EX_Valid, EX_WBCtrl, EX_MEMCtrl, EX_RegDst, EX_ALUSrc, EX_ALUOp, EX_halfbyte,
               EX_PCAddResult, EX_Read1, EX_Read2, EX_SignExtend, EX_SignExtend_10_6,
               EX_Rs, EX_Rt, EX_Rd, StallCount, BubbleCount
    );

    modport slave (
        input  Stall, Flush, ID_Valid, ID_WB_Ctrl, ID_MEM_Ctrl, ID_EX_Ctrl,
               ID_PCAddResult, ID_Read1, ID_Read2, ID_SignExtend, ID_SignExtend_10_6,
               ID_Rs, ID_Rt, ID_Rd,
        output EX_Valid, EX_WBCtrl, EX_MEMCtrl, EX_RegDst, EX_ALUSrc, EX_ALUOp, EX_halfbyte,
               EX_PCAddResult, EX_Read1, EX_Read2, EX_SignExtend, EX_SignExtend_10_6,
               EX_Rs, EX_Rt, EX_Rd, StallCount, BubbleCount
    );

endinterface

// File: rtl/id_ex_pipe_stage_pipe_reg.sv
// Generic pipeline register: reset and clear force zero, enable loads D,
// otherwise the contents hold.
module pipe_reg #(
    parameter int W = 8
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic         En,
    input  logic         Clr,
    input  logic [W-1:0] D,
    output logic [W-1:0] Q
);

    // Reset > Clr > En > hold
    always_ff @(posedge Clk) begin
        if (Reset)
            Q <= '0;
        else if (Clr)
            Q <= '0;
        else if (En)
            Q <= D;
    end

endmodule

// File: rtl/id_ex_pipe_stage.sv
// ID->EX pipeline stage: control and data registers with stall/flush,
// EX bundle field split and saturating stall/bubble event counters.
module id_ex_pipe_stage
    import id_ex_pipe_stage_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int REG_W   = REG_W_DEF,
    parameter int WB_W    = WB_W_DEF,
    parameter int MEM_W   = MEM_W_DEF,
    parameter int ALUOP_W = ALUOP_W_DEF,
    parameter int CNT_W   = CNT_W_DEF
) (
    input logic             Clk,
    input logic             Reset,
    id_ex_pipe_stage_if.slave bus
);

    localparam int EX_W    = ALUOP_W + 5;
    localparam int CTRL_W  = WB_W + MEM_W + EX_W;
    localparam int DVEC_W  = 1 + 5 * DATA_W + 3 * REG_W;
    localparam int HB_LSB  = halfbyte_lsb(ALUOP_W);

    logic              load_en;
    logic              ctrl_clr;
    logic [CTRL_W-1:0] ctrl_d;
    logic [CTRL_W-1:0] ctrl_q;
    logic [DVEC_W-1:0] data_d;
    logic [DVEC_W-1:0] data_q;
    logic [EX_W-1:0]   ex_q;
    logic [CNT_W-1:0]  stall_cnt;
    logic [CNT_W-1:0]  bubble_cnt;

    assign load_en = ~bus.Stall;
    // An invalid ID slot only zeroes the controls when it is actually loaded;
    // while stalled the held controls must survive.
    assign ctrl_clr = bus.Flush | (load_en & ~bus.ID_Valid);

    assign ctrl_d = {bus.ID_WB_Ctrl, bus.ID_MEM_Ctrl, bus.ID_EX_Ctrl};
    assign data_d = {bus.ID_Valid, bus.ID_PCAddResult, bus.ID_Read1, bus.ID_Read2,
                     bus.ID_SignExtend, bus.ID_SignExtend_10_6,
                     bus.ID_Rs, bus.ID_Rt, bus.ID_Rd};

    pipe_reg #(.W(CTRL_W)) u_ctrl_reg (
        .Clk   (Clk),
        .Reset (Reset),
        .En    (load_en),
        .Clr   (ctrl_clr),
        .D     (ctrl_d),
        .Q     (ctrl_q)
    );

    pipe_reg #(.W(DVEC_W)) u_data_reg (
        .Clk   (Clk),
        .Reset (Reset),
        .En    (load_en),
        .Clr   (bus.Flush),
        .D     (data_d),
        .Q     (data_q)
    );

    assign {bus.EX_WBCtrl, bus.EX_MEMCtrl, ex_q} = ctrl_q;
    assign bus.EX_RegDst   = ex_q[REGDST_LSB +: 2];
    assign bus.EX_ALUSrc   = ex_q[ALUSRC_BIT];
    assign bus.EX_ALUOp    = ex_q[ALUOP_LSB +: ALUOP_W];
    assign bus.EX_halfbyte = ex_q[HB_LSB +: 2];

    assign {bus.EX_Valid, bus.EX_PCAddResult, bus.EX_Read1, bus.EX_Read2,
            bus.EX_SignExtend, bus.EX_SignExtend_10_6,
            bus.EX_Rs, bus.EX_Rt, bus.EX_Rd} = data_q;

    // Saturating event counters; flush takes precedence over stall
    always_ff @(posedge Clk) begin
        if (Reset) begin
            stall_cnt  <= '0;
            bubble_cnt <= '0;
        end else if (bus.Flush) begin
            if (bubble_cnt != {CNT_W{1'b1}})
                bubble_cnt <= bubble_cnt + CNT_W'(1);
        end else if (bus.Stall) begin
            if (stall_cnt != {CNT_W{1'b1}})
                stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

    assign bus.StallCount  = stall_cnt;
    assign bus.BubbleCount = bubble_cnt;

endmodule
